memory_access: RTL and testbench

Memory stage of the RV32I pipeline, directly upstream of the writeback decode. It takes the executed instruction and ALU result and performs LOAD/STORE accesses to data memory over a req/ack handshake, with byte-lane alignment and sign/zero extension. It then presents the retired instruction and write data to writeback. Writeback derives its register write enable and `rd` from `instruction_out` alone. Any instruction that must not write therefore leaves this stage as a canonical NOP.

---
 rtl/memory_access_pkg.sv | 50 +++++
 rtl/memory_access_load_align.sv | 35 +++
 rtl/memory_access.sv | 150 +++++++++++++++
 tb/tb_memory_access.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared encodings for the RV32I memory stage: opcodes, funct3 size codes,
// the canonical NOP and the access-size classification helpers.
package memory_access_pkg;

    localparam logic [6:0]  OP_LOAD      = 7'b0000011;
    localparam logic [6:0]  OP_STORE     = 7'b0100011;

    localparam logic [2:0]  F3_B         = 3'b000;
    localparam logic [2:0]  F3_H         = 3'b001;
    localparam logic [2:0]  F3_W         = 3'b010;
    localparam logic [2:0]  F3_BU        = 3'b100;
    localparam logic [2:0]  F3_HU        = 3'b101;

    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } size_e;

    // Unsigned variants share the width of their signed counterparts;
    // any unrecognised funct3 is treated as a full word.
    function automatic size_e size_of(input logic [2:0] funct3);
        size_e sz;
        case (funct3)
            F3_B, F3_BU: sz = SIZE_B;
            F3_H, F3_HU: sz = SIZE_H;
            F3_W:        sz = SIZE_W;
            default:     sz = SIZE_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] offset);
        logic bad;
        case (sz)
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Load-data lane selection and sign/zero extension for the memory stage.
// Purely combinational: read word + byte offset + funct3 -> 32-bit result.
module load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    result = {{16{half_lane[15]}}, half_lane};
            F3_BU:   result = {24'h000000, byte_lane};
            F3_HU:   result = {16'h0000, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV32I memory stage: issues LOAD/STORE over a req/ack data-memory handshake
// and hands retired instructions (or a NOP for faults/bubbles) to writeback.
module memory_access
    import memory_access_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] instruction_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] instruction_out,
    output logic [31:0] wb_data,
    output logic        valid_out,
    output logic        misaligned
);

    state_e      state;
    logic [31:0] insn_q;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        bad_align;
    size_e       size_in;
    logic [3:0]  strobe;
    logic [31:0] lanes;
    logic [31:0] load_result;

    always_comb begin
        opcode    = instruction_in[6:0];
        funct3    = instruction_in[14:12];
        offset    = alu_result[1:0];
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_mem    = is_load || is_store;
        size_in   = size_of(funct3);
        bad_align = is_misaligned(size_in, offset);
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        strobe = 4'b1111;
        lanes  = store_data;
        case (size_in)
            SIZE_B: begin
                strobe = 4'b0001 << offset;
                lanes  = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                strobe = 4'b0011 << offset;
                lanes  = {2{store_data[15:0]}};
            end
            default: begin
                strobe = 4'b1111;
                lanes  = store_data;
            end
        endcase
    end

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    assign stall = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_wstrb      <= '0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            valid_out       <= 1'b0;
            misaligned      <= 1'b0;
            instruction_out <= NOP_INSN;
            wb_data         <= '0;
            insn_q          <= NOP_INSN;
            offset_q        <= '0;
            funct3_q        <= '0;
            is_load_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out       <= 1'b0;
                    misaligned      <= 1'b0;
                    instruction_out <= NOP_INSN;
                    wb_data         <= '0;
                    if (valid_in) begin
                        if (!is_mem) begin
                            instruction_out <= instruction_in;
                            wb_data         <= alu_result;
                            valid_out       <= 1'b1;
                        end else if (bad_align) begin
                            // Faulted access retires as a NOP so writeback never writes rd.
                            valid_out  <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            insn_q     <= instruction_in;
                            offset_q   <= offset;
                            funct3_q   <= funct3;
                            is_load_q  <= is_load;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {alu_result[31:2], 2'b00};
                            dmem_wdata <= lanes;
                            dmem_wstrb <= is_store ? strobe : 4'b0000;
                            state      <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        dmem_wstrb      <= '0;
                        valid_out       <= 1'b1;
                        instruction_out <= insn_q;
                        wb_data         <= is_load_q ? load_result : 32'h0000_0000;
                        state           <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever valid_out is presented.
module tb_memory_access;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ADDI  = 32'h00510093;
    localparam logic [31:0] I_LB    = 32'h00008283;
    localparam logic [31:0] I_LH    = 32'h00009283;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_LBU   = 32'h0000C283;
    localparam logic [31:0] I_LHU   = 32'h0000D283;
    localparam logic [31:0] I_SB    = 32'h00208023;
    localparam logic [31:0] I_SH    = 32'h00209023;
    localparam logic [31:0] I_SW    = 32'h0020A023;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] instruction_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] instruction_out;
    logic [31:0] wb_data;
    logic        valid_out;
    logic        misaligned;

    memory_access #(.NOP_INSN(32'h0000_0013)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .instruction_in  (instruction_in),
        .alu_result      (alu_result),
        .store_data      (store_data),
        .stall           (stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .instruction_out (instruction_out),
        .wb_data         (wb_data),
        .valid_out       (valid_out),
        .misaligned      (misaligned)
    );

    typedef struct {
        logic [31:0] insn;
        logic [31:0] wb;
        logic        mis;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] insn, input logic [31:0] wb,
                            input logic mis, input int unsigned at);
        exp_t e;
        e.insn = insn;
        e.wb   = wb;
        e.mis  = mis;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    // Monitor: every retirement must match the head of the scoreboard,
    // and every non-retiring cycle must show the bubble values.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire insn=%h wb=%h expected no retirement", instruction_out, wb_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("retire_insn", instruction_out, mon_e.insn);
                    check("retire_wb", wb_data, mon_e.wb);
                    check("retire_misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
                    check("retire_cycle", cyc, mon_e.cyc);
                end
            end else if (rst === 1'b0) begin
                check("bubble_insn", instruction_out, NOP);
                check("bubble_wb", wb_data, 32'h0);
                check("bubble_misaligned", {31'b0, misaligned}, 32'h0);
            end
        end
    end

    task automatic issue_alu(input logic [31:0] insn, input logic [31:0] alu);
        instruction_in = insn;
        alu_result     = alu;
        valid_in       = 1'b1;
        push_exp(insn, alu, 1'b0, cyc + 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("alu_stall", {31'b0, stall}, 32'h0);
        check("alu_no_req", {31'b0, dmem_req}, 32'h0);
    endtask

    task automatic issue_misaligned(input logic [31:0] insn, input logic [31:0] addr);
        instruction_in = insn;
        alu_result     = addr;
        store_data     = 32'hA5A5_A5A5;
        valid_in       = 1'b1;
        push_exp(NOP, 32'h0, 1'b1, cyc + 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("mis_no_req", {31'b0, dmem_req}, 32'h0);
        check("mis_stall", {31'b0, stall}, 32'h0);
    endtask

    task automatic mem_op(input logic [31:0] insn, input logic [31:0] addr,
                          input logic [31:0] sd, input int unsigned k,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic exp_we, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        int unsigned stall_cycles;
        instruction_in = insn;
        alu_result     = addr;
        store_data     = sd;
        valid_in       = 1'b1;
        push_exp(insn, exp_wb, 1'b0, cyc + 1 + k);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("mem_req", {31'b0, dmem_req}, 32'h1);
        check("mem_addr", dmem_addr, exp_addr);
        check("mem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        if (exp_we) begin
            check("mem_wstrb", {28'b0, dmem_wstrb}, {28'b0, exp_wstrb});
            check("mem_wdata", dmem_wdata, exp_wdata);
        end
        stall_cycles = 0;
        for (int unsigned i = 1; i <= k; i++) begin
            if (stall === 1'b1) stall_cycles++;
            check("mem_req_held", {31'b0, dmem_req}, 32'h1);
            check("mem_addr_held", dmem_addr, exp_addr);
            if (i == k) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hDEAD_0000;
        check("mem_stall_cycles", stall_cycles, k);
        check("mem_stall_released", {31'b0, stall}, 32'h0);
        check("mem_req_dropped", {31'b0, dmem_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        valid_in       = 1'b0;
        instruction_in = 32'h0;
        alu_result     = 32'h0;
        store_data     = 32'h0;
        dmem_rdata     = 32'h0;
        dmem_ack       = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        check("rst_req", {31'b0, dmem_req}, 32'h0);
        check("rst_we", {31'b0, dmem_we}, 32'h0);
        check("rst_wstrb", {28'b0, dmem_wstrb}, 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_misaligned", {31'b0, misaligned}, 32'h0);
        check("rst_insn", instruction_out, NOP);
        check("rst_wb", wb_data, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue_alu(I_ADD, 32'h0000_1234);
        @(posedge clk); #1;
        issue_alu(I_ADDI, 32'hFFFF_FFFB);

        mem_op(I_LB,  32'h0000_0103, 32'h0, 3, 32'h80FF_00AA, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80);
        mem_op(I_LBU, 32'h0000_0103, 32'h0, 3, 32'h80FF_00AA, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0000_0080);
        mem_op(I_LH,  32'h0000_0102, 32'h0, 1, 32'h80FF_00AA, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'hFFFF_80FF);
        mem_op(I_LHU, 32'h0000_0102, 32'h0, 2, 32'h80FF_00AA, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0000_80FF);
        mem_op(I_LH,  32'h0000_0200, 32'h0, 1, 32'h1234_8001, 32'h0000_0200, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001);
        mem_op(I_LW,  32'h0000_0104, 32'h0, 2, 32'hCAFE_F00D, 32'h0000_0104, 1'b0, 4'h0, 32'h0, 32'hCAFE_F00D);
        mem_op(I_SH,  32'h0000_0202, 32'hDEAD_BEEF, 2, 32'h1234_5678, 32'h0000_0200, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        mem_op(I_SB,  32'h0000_0301, 32'h0000_0055, 1, 32'hFFFF_FFFF, 32'h0000_0300, 1'b1, 4'b0010, 32'h5555_5555, 32'h0);
        mem_op(I_SW,  32'h0000_0008, 32'h0102_0304, 1, 32'h0, 32'h0000_0008, 1'b1, 4'b1111, 32'h0102_0304, 32'h0);

        issue_misaligned(I_LW, 32'h0000_0101);
        issue_misaligned(I_LH, 32'h0000_0101);
        issue_misaligned(I_SW, 32'h0000_0102);
        @(posedge clk); #1;

        // Ack while idle must not produce a retirement.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("idle_ack_req", {31'b0, dmem_req}, 32'h0);
        check("idle_ack_stall", {31'b0, stall}, 32'h0);

        // Reset while a load is outstanding; the late ack is dropped.
        instruction_in = I_LW;
        alu_result     = 32'h0000_0040;
        valid_in       = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("abort_req_before", {31'b0, dmem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req_after", {31'b0, dmem_req}, 32'h0);
        check("abort_stall_after", {31'b0, stall}, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("abort_late_ack_valid", {31'b0, valid_out}, 32'h0);
        check("abort_late_ack_req", {31'b0, dmem_req}, 32'h0);
        issue_alu(I_ADD, 32'h0000_0ABC);

        // Back-to-back LW then ADD: ack in first request cycle, ADD held
        // through the stall and accepted after the bubble.
        instruction_in = I_LW;
        alu_result     = 32'h0000_0000;
        valid_in       = 1'b1;
        push_exp(I_LW, 32'hCAFE_F00D, 1'b0, cyc + 2);
        @(posedge clk); #1;
        check("b2b_stall_access", {31'b0, stall}, 32'h1);
        dmem_ack       = 1'b1;
        dmem_rdata     = 32'hCAFE_F00D;
        instruction_in = I_ADD;
        alu_result     = 32'h0000_55AA;
        push_exp(I_ADD, 32'h0000_55AA, 1'b0, cyc + 2);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("b2b_stall_bubble", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("b2b_add_no_stall", {31'b0, stall}, 32'h0);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
